fp32_addsub_issue: RTL and testbench
====================================

Name: fp32_addsub_issue

Overview:
- Sequential issue stage directly upstream of the combinational FP32 add/sub unit (`FP_32_add_or_sub`, operands add1/add2/command, result out).
- Buffers operand pairs in a small FIFO with valid/ready input and drives registered operands into the adder.
- Captures the adder result into an output register with valid/ready back-pressure.
- Optionally overrides the adder result for IEEE-754 NaN and infinity special cases.

Parameters:
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- QNAN, 32'h7FC00000: canonical quiet NaN emitted on special-case override.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; combinational, equals !full.
- in_a  in  32  FP32 operand A.
- in_b  in  32  FP32 operand B.
- in_cmd  in  1  1 = add (A+B), 0 = subtract (A−B).
- op_a  out  32  registered operand to adder add1.
- op_b  out  32  registered operand to adder add2.
- op_cmd  out  1  registered command to adder.
- op_res  in  32  combinational adder result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  registered result.
- out_flags  out  2  {nan, inf}; registered with out_result.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, op_a/op_b=0, op_cmd=0, out_valid=0, out_result=0, out_flags=0, FSM=IDLE. in_ready=1 while rst is high. Any in-flight entry or result is discarded.
- Push: a FIFO write occurs when in_valid && in_ready. Stored entry is {in_a, in_b, in_cmd}. Pointers wrap modulo DEPTH.
- Full FIFO: no write even if a pop happens in the same cycle (no same-cycle full bypass).
- Simultaneous push and pop when not full: count unchanged, both take effect.
- FSM has three states: IDLE, ISSUE, HOLD.
  - IDLE: if FIFO is non-empty, pop the head into op_a/op_b/op_cmd and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: op_* are stable and op_res has settled. Load out_result/out_flags (override rule below), set out_valid=1, go to HOLD.
  - HOLD: out_valid stays 1 and out_result/out_flags stay stable until out_ready=1.
    - On handshake with FIFO non-empty: pop the next entry into op_*, clear out_valid, go to ISSUE.
    - On handshake with FIFO empty: clear out_valid, go to IDLE.
- op_* registers hold their value except on a pop.
- Latency: push accepted at edge t into an empty FIFO with FSM in IDLE gives op_* valid after t+1 and out_valid after t+2.
- Throughput: one result per 2 cycles when out_ready is held high.
- Back-pressure capacity: with out_ready=0, DEPTH+1 pairs are accepted (one in op_*, DEPTH in the FIFO).
- Effective sign of B = in_b[31] ^ ~op_cmd.
- Classification is performed on op_a/op_b in ISSUE:
  - NaN: exponent == 8'hFF and mantissa != 0.
  - Inf: exponent == 8'hFF and mantissa == 0.

Optional Feature:
- Macro: FP_SPECIAL_BYPASS_EN.
- With the macro defined, in ISSUE:
  - If either operand is NaN, or both operands are Inf with op_a[31] != effective sign of B: out_result=QNAN, out_flags=2'b10.
  - Else if exactly one operand is Inf, or both are Inf with matching signs: out_result is that infinity, with B's sign replaced by its effective sign. out_flags=2'b01.
  - Otherwise: out_result=op_res, out_flags=0.
- Without the macro: out_result=op_res always and out_flags tied to 2'b00.

Test Plan:
- Subtract: push A=32'h40800000, B=32'h40000000, cmd=0, out_ready=1 → out_valid 2 cycles after push, out_result=32'h40000000 (4.0−2.0), flags=0.
- Add, then back-to-back: same operands with cmd=1 → 32'h40C00000; a second pair A=32'h3FC00001, B=32'h3FC02000, cmd=1 pushed next cycle → results arrive in order, 2 cycles apart.
- Back-pressure: out_ready=0, push 6 pairs → in_ready drops after 5 accepted and count=4. Raise out_ready → all 5 results delivered in push order, out_result stable while out_valid && !out_ready.
- Special (macro on): A=32'h7F800000, B=32'h7F800000, cmd=0 → 32'h7FC00000, flags=2'b10. A=32'h7FC00001, B=32'h40000000, cmd=1 → 32'h7FC00000, flags=2'b10. A=32'h40000000, B=32'hFF800000, cmd=0 → 32'h7F800000, flags=2'b01.
- Reset mid-operation: assert rst while in HOLD with 3 entries queued → same cycle out_valid=0, count=0, in_ready=1. After release, no stale results emerge.
- Pointer wrap: 2·DEPTH+1 push/pop pairs with random out_ready → each result matches its own operands, count never exceeds DEPTH.

Source files
------------

// File: rtl/fp32_addsub_issue_if.sv
// Bundle for the FP32 add/sub issue stage: operand input handshake, adder-side
// operand/result wires, result output handshake and FIFO occupancy.
interface fp32_addsub_issue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          in_cmd;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          op_cmd;
  logic [31:0]   op_res;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [1:0]    out_flags;
  logic [CW-1:0] count;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable while valid is high and ready is low.
  modport slave (
    input  in_valid, in_a, in_b, in_cmd, op_res, out_ready,
    output in_ready, op_a, op_b, op_cmd, out_valid, out_result, out_flags, count
  );

  modport master (
    output in_valid, in_a, in_b, in_cmd, op_res, out_ready,
    input  in_ready, op_a, op_b, op_cmd, out_valid, out_result, out_flags, count
  );
endinterface

// File: rtl/fp32_addsub_issue.sv
// Issue stage for a combinational FP32 add/sub: operand FIFO, IDLE/ISSUE/HOLD FSM, result register.
// Define FP_SPECIAL_BYPASS_EN to override the adder result for NaN/Inf operands.
module fp32_addsub_issue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic               clk,
  input  logic               rst,
  fp32_addsub_issue_if.slave bus,
  output logic [1:0]         dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || QNAN[30:23] != 8'hFF || QNAN[22:0] == 23'd0)
    begin : g_bad_config
      $error("fp32_addsub_issue: DEPTH must be a power of two >= 2 and QNAN must be a NaN");
    end

  state_e        state_q, state_d;
  logic [64:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop, load_res;
  logic [31:0]   op_a_q, op_b_q;
  logic          op_cmd_q;
  logic          out_valid_q;
  logic [31:0]   result_q, result_d;
  logic [1:0]    flags_q, flags_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A full FIFO refuses writes even when the head is popped in the same cycle.
  assign push  = bus.in_valid && !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_cmd};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_res = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        load_res = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          pop     = !empty;
          state_d = empty ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d = bus.op_res;
    flags_d  = 2'b00;
`ifdef FP_SPECIAL_BYPASS_EN
    begin : special_override
      logic a_nan, b_nan, a_inf, b_inf, b_sign;
      a_nan  = (op_a_q[30:23] == 8'hFF) && (op_a_q[22:0] != 23'd0);
      b_nan  = (op_b_q[30:23] == 8'hFF) && (op_b_q[22:0] != 23'd0);
      a_inf  = (op_a_q[30:23] == 8'hFF) && (op_a_q[22:0] == 23'd0);
      b_inf  = (op_b_q[30:23] == 8'hFF) && (op_b_q[22:0] == 23'd0);
      // Subtraction is addition of B with its sign flipped.
      b_sign = op_b_q[31] ^ ~op_cmd_q;
      if (a_nan || b_nan || (a_inf && b_inf && (op_a_q[31] != b_sign))) begin
        result_d = QNAN;
        flags_d  = 2'b10;
      end else if (a_inf) begin
        result_d = op_a_q;
        flags_d  = 2'b01;
      end else if (b_inf) begin
        result_d = {b_sign, op_b_q[30:0]};
        flags_d  = 2'b01;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cmd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q <= state_d;
      if (pop) {op_a_q, op_b_q, op_cmd_q} <= mem_q[rd_ptr_q];
      if (load_res) begin
        out_valid_q <= 1'b1;
        result_q    <= result_d;
        flags_q     <= flags_d;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = !full;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.op_cmd     = op_cmd_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;
  assign bus.count      = count_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_fp32_addsub_issue.sv
// Bench for fp32_addsub_issue: directed test-plan cases plus randomized traffic
// scored against a reference model; also covers FP_SPECIAL_BYPASS_EN builds.
module tb_fp32_addsub_issue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  fp32_addsub_issue_if #(.DEPTH(DEPTH)) bus ();

  fp32_addsub_issue #(.DEPTH(DEPTH), .QNAN(QNAN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Stand-in for the external combinational adder: exact results for the
  // directed operand pairs, an arbitrary operand-dependent word otherwise.
  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic cmd);
    if (a == 32'h40800000 && b == 32'h40000000) return cmd ? 32'h40C00000 : 32'h40000000;
    if (a == 32'h3FC00001 && b == 32'h3FC02000 && cmd) return 32'h40401000;
    return (a ^ {b[15:0], b[31:16]}) + {31'd0, cmd};
  endfunction

  assign bus.op_res = adder_model(bus.op_a, bus.op_b, bus.op_cmd);

  // Expected {flags, result} for one operand pair, from the IEEE special-case rules.
  function automatic logic [33:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic cmd);
    logic [33:0] r;
    r = {2'b00, adder_model(a, b, cmd)};
`ifdef FP_SPECIAL_BYPASS_EN
    begin
      bit          a_nan, b_nan, a_inf, b_inf;
      logic        eff_sign;
      logic [31:0] eff_b;
      a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      eff_sign = cmd ? b[31] : ~b[31];
      eff_b    = {eff_sign, b[30:0]};
      if (a_nan || b_nan)                       r = {2'b10, QNAN};
      else if (a_inf && b_inf)                  r = (a == eff_b) ? {2'b01, a} : {2'b10, QNAN};
      else if (a_inf)                           r = {2'b01, a};
      else if (b_inf)                           r = {2'b01, eff_b};
    end
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0:       v = {v[31], 8'hFF, 23'd0};
      1:       v = {v[31], 8'hFF, v[22:1], 1'b1};
      default: v = v;
    endcase
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [31:0] res_log[$];
  int          hs_log[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          hold_prev = 1'b0;
  logic [33:0] hold_val;
  logic [31:0] last_res;
  logic [1:0]  last_flags;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge with inputs already driven for this cycle.
  task automatic run_cycle();
    logic [33:0] e;
    #1;
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_result(bus.in_a, bus.in_b, bus.in_cmd));
    if (hold_prev) begin
      check_eq("hold_valid", bus.out_valid, 1);
      check_eq("hold_stable", {bus.out_flags, bus.out_result}, hold_val);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_result", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("result", {bus.out_flags, bus.out_result}, e);
        last_res   = bus.out_result;
        last_flags = bus.out_flags;
        res_log.push_back(bus.out_result);
        hs_log.push_back(cyc);
      end
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    hold_val  = {bus.out_flags, bus.out_result};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_pair(input logic [31:0] a, input logic [31:0] b, input logic cmd);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cmd   = cmd;
  endtask

  task automatic drain(input int budget);
    bus.in_valid = 1'b0;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) run_cycle();
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic cmd,
                        input logic [31:0] exp_res, input logic [1:0] exp_flags, input string tag);
    bus.out_ready = 1'b1;
    set_pair(a, b, cmd);
    run_cycle();
    drain(20);
    check_eq({tag, "_result"}, last_res, exp_res);
    check_eq({tag, "_flags"}, last_flags, exp_flags);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepted;
    int pushed;
    int budget;
    bit holding;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cmd    = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_result", bus.out_result, 0);
    check_eq("rst_out_flags", bus.out_flags, 0);
    check_eq("rst_op_a", bus.op_a, 0);
    check_eq("rst_op_b", bus.op_b, 0);
    check_eq("rst_op_cmd", bus.op_cmd, 0);
    check_eq("rst_state", dbg_state, 0);
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Subtract with latency checks: op_* after one edge, out_valid after two.
    bus.out_ready = 1'b1;
    set_pair(32'h40800000, 32'h40000000, 1'b0);
    run_cycle();
    bus.in_valid = 1'b0;
    check_eq("lat_count_after_push", bus.count, 1);
    check_eq("lat_valid_t0", bus.out_valid, 0);
    run_cycle();
    check_eq("lat_op_a", bus.op_a, 32'h40800000);
    check_eq("lat_op_b", bus.op_b, 32'h40000000);
    check_eq("lat_op_cmd", bus.op_cmd, 0);
    check_eq("lat_valid_t1", bus.out_valid, 0);
    run_cycle();
    check_eq("lat_valid_t2", bus.out_valid, 1);
    drain(10);
    check_eq("sub_result", last_res, 32'h40000000);
    check_eq("sub_flags", last_flags, 0);

    // Add followed by a back-to-back second pair.
    res_log.delete();
    hs_log.delete();
    set_pair(32'h40800000, 32'h40000000, 1'b1);
    run_cycle();
    set_pair(32'h3FC00001, 32'h3FC02000, 1'b1);
    run_cycle();
    drain(20);
    check_eq("b2b_count", res_log.size(), 2);
    if (res_log.size() == 2) begin
      check_eq("b2b_first", res_log[0], 32'h40C00000);
      check_eq("b2b_second", res_log[1], 32'h40401000);
      check_eq("b2b_spacing", hs_log[1] - hs_log[0], 2);
    end

    // Back-pressure: six attempts, DEPTH+1 accepted.
    bus.out_ready = 1'b0;
    accepted = 0;
    set_pair(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (accepted < 6);
      holding = bus.in_valid && !bus.in_ready;
      if (bus.in_valid && bus.in_ready) accepted++;
      run_cycle();
      if (!holding) begin
        bus.in_a   = rand_fp();
        bus.in_b   = rand_fp();
        bus.in_cmd = 1'($urandom_range(0, 1));
      end
    end
    bus.in_valid = 1'b0;
    check_eq("bp_accepted", accepted, DEPTH + 1);
    check_eq("bp_in_ready", bus.in_ready, 0);
    check_eq("bp_count", bus.count, DEPTH);
    res_log.delete();
    bus.out_ready = 1'b1;
    drain(60);
    check_eq("bp_delivered", res_log.size(), DEPTH + 1);

`ifdef FP_SPECIAL_BYPASS_EN
    single(32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 2'b10, "inf_minus_inf");
    single(32'h7FC00001, 32'h40000000, 1'b1, 32'h7FC00000, 2'b10, "nan_plus_num");
    single(32'h40000000, 32'hFF800000, 1'b0, 32'h7F800000, 2'b01, "num_minus_neginf");
`else
    single(32'h7F800000, 32'h7F800000, 1'b0, adder_model(32'h7F800000, 32'h7F800000, 1'b0),
           2'b00, "inf_passthru");
`endif

    // Reset while HOLDing with three entries queued.
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 12 && accepted < 4; i++) begin
      set_pair(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
      if (bus.in_ready) accepted++;
      run_cycle();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) run_cycle();
    check_eq("pre_rst_valid", bus.out_valid, 1);
    check_eq("pre_rst_count", bus.count, 3);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", bus.out_valid, 0);
    check_eq("mid_rst_count", bus.count, 0);
    check_eq("mid_rst_in_ready", bus.in_ready, 1);
    check_eq("mid_rst_state", dbg_state, 0);
    exp_q.delete();
    hold_prev = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("post_rst_no_stale", bus.out_valid, 0);
      run_cycle();
    end
    check_eq("post_rst_count", bus.count, 0);

    // Randomized traffic with random back-pressure; wraps the pointers many times.
    pushed  = 0;
    budget  = 3000;
    holding = 1'b0;
    bus.in_valid = 1'b0;
    while ((pushed < 40 || exp_q.size() != 0) && budget > 0) begin
      budget--;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!holding) begin
        if (pushed < 40 && $urandom_range(0, 2) != 0) set_pair(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
        else bus.in_valid = 1'b0;
      end
      holding = bus.in_valid && !bus.in_ready;
      if (bus.in_valid && bus.in_ready) pushed++;
      check_eq("count_le_depth", bus.count <= DEPTH, 1);
      run_cycle();
      if (!holding) bus.in_valid = 1'b0;
    end
    check_eq("random_timeout", budget > 0, 1);
    check_eq("random_all_scored", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
